// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button front end (synchroniser, debouncer, edge pulses,
// optional auto-repeat).
// Optional auto-repeat is built only when BTN_AUTOREPEAT_EN is defined;
// otherwise o_repeat stays 0 and o_step equals o_press.
//
// Repeat FSM (BTN_AUTOREPEAT_EN only):
//   state     | meaning
//   ST_IDLE   | button released, repeat counter held at 0
//   ST_HOLD   | pressed, counting towards the first repeat (HOLD_COUNT)
//   ST_REPEAT | held past the first repeat, pulsing every REPEAT_COUNT
module btn_conditioner #(
  parameter int DB_COUNT     = 500_000,
  parameter int HOLD_COUNT   = 12_500_000,
  parameter int REPEAT_COUNT = 2_500_000
) (
  input  logic i_sysclk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_db,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_step
);

  localparam int DBW = $clog2(DB_COUNT) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_COUNT - 1);

  logic           sync_1;
  logic           sync_2;
  logic [DBW-1:0] db_cnt;
  logic           db_hit;
  logic           rise;
  logic           fall;
  logic           rep_fire;

  // A level change is accepted on the cycle the counter reaches its last value.
  assign db_hit = (sync_2 != o_db) && (db_cnt == DB_LAST);
  assign rise   = db_hit & sync_2;
  assign fall   = db_hit & ~sync_2;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= i_btn;
      sync_2 <= sync_1;
    end
  end

  // Debounce: count consecutive cycles where the synchronised level differs.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      db_cnt <= '0;
      o_db   <= 1'b0;
    end else if (sync_2 == o_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      o_db   <= sync_2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DBW'(1);
    end
  end

  // Registered single-cycle pulses, all updated on the same edge as o_db.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_repeat  <= 1'b0;
      o_step    <= 1'b0;
    end else begin
      o_press   <= rise;
      o_release <= fall;
      o_repeat  <= rep_fire;
      o_step    <= rise | rep_fire;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (HOLD_COUNT > REPEAT_COUNT) ? HOLD_COUNT : REPEAT_COUNT;
  localparam int RW      = $clog2(RPT_MAX) + 1;
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_COUNT - 1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] rpt_cnt;
  logic          rpt_clr;

  // State register.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a debounced fall always wins over a pending repeat.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (rise) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (fall)                        state_nxt = ST_IDLE;
        else if (rpt_cnt == HOLD_LAST)   state_nxt = ST_REPEAT;
      end
      ST_REPEAT: if (fall) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: repeat strobe and counter clear.
  always_comb begin
    rep_fire = 1'b0;
    rpt_clr  = 1'b0;
    case (state)
      ST_HOLD: begin
        if (fall) begin
          rpt_clr = 1'b1;
        end else if (rpt_cnt == HOLD_LAST) begin
          rep_fire = 1'b1;
          rpt_clr  = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (fall) begin
          rpt_clr = 1'b1;
        end else if (rpt_cnt == RPT_LAST) begin
          rep_fire = 1'b1;
          rpt_clr  = 1'b1;
        end
      end
      default: rpt_clr = 1'b1;
    endcase
  end

  // Repeat interval counter, cleared on every state transition point.
  always_ff @(posedge i_sysclk) begin
    if (i_rst)        rpt_cnt <= '0;
    else if (rpt_clr) rpt_cnt <= '0;
    else              rpt_cnt <= rpt_cnt + RW'(1);
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_COUNT=4, HOLD_COUNT=10,
// REPEAT_COUNT=5. Builds with or without BTN_AUTOREPEAT_EN.
// Edge numbering: E0 is the first edge that samples the new i_btn level;
// the debounced update (and o_press/o_release) lands on E5.
module tb_btn_conditioner;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic i_sysclk = 1'b0;
  logic i_rst    = 1'b1;
  logic i_btn    = 1'b0;
  logic o_db, o_press, o_release, o_repeat, o_step;

  int checks = 0;
  int errors = 0;

  logic [4:0] obs;
  logic [4:0] exp_v;
  assign obs = {o_db, o_press, o_release, o_repeat, o_step};

  btn_conditioner #(
    .DB_COUNT    (4),
    .HOLD_COUNT  (10),
    .REPEAT_COUNT(5)
  ) dut (
    .i_sysclk (i_sysclk),
    .i_rst    (i_rst),
    .i_btn    (i_btn),
    .o_db     (o_db),
    .o_press  (o_press),
    .o_release(o_release),
    .o_repeat (o_repeat),
    .o_step   (o_step)
  );

  always #5 i_sysclk = ~i_sysclk;

  // Advance one edge and land 1 ns after it.
  task automatic tick();
    @(posedge i_sysclk);
    #1;
  endtask

  // Release the button and let the debouncer and FSM return to idle.
  task automatic settle();
    i_btn = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_btn = 1'b1;
    repeat (3) tick();
    exp_v = 5'b00000;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset {db,press,rel,rep,step}=%b exp %b", obs, exp_v);
    end
    i_btn = 1'b0;
    tick();
    i_rst = 1'b0;
    repeat (4) tick();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_idle {db,press,rel,rep,step}=%b exp %b", obs, exp_v);
    end
  endtask

  task automatic test_clean_press();
    i_btn = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      exp_v = {(e >= 5), (e == 5), 1'b0, 1'b0, (e == 5)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL clean_press E%0d {db,press,rel,rep,step}=%b exp %b", e, obs, exp_v);
      end
    end
    settle();
  endtask

  task automatic test_glitch();
    // 3-cycle pulse: must be rejected.
    i_btn = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (e == 2) i_btn = 1'b0;
      exp_v = 5'b00000;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL glitch3 E%0d {db,press,rel,rep,step}=%b exp %b", e, obs, exp_v);
      end
    end
    // 4-cycle pulse: accepted, release 4 cycles after o_db rises.
    i_btn = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      tick();
      if (e == 3) i_btn = 1'b0;
      exp_v = {(e >= 5 && e < 9), (e == 5), (e == 9), 1'b0, (e == 5)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL glitch4 E%0d {db,press,rel,rep,step}=%b exp %b", e, obs, exp_v);
      end
    end
    settle();
  endtask

  // Press at E5 (N); held until N+40, debounced fall at E51 (N+46).
  // With repeat enabled: repeats at E15, E20, ..., E50.
  task automatic test_hold_repeat();
    logic rep;
    i_btn = 1'b1;
    for (int e = 0; e <= 65; e++) begin
      tick();
      if (e == 45) i_btn = 1'b0;
      rep = REP_EN && (e >= 15) && (e <= 50) && ((e - 15) % 5 == 0);
      exp_v = {(e >= 5 && e < 51), (e == 5), (e == 51), rep, (e == 5) || rep};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL hold_repeat E%0d {db,press,rel,rep,step}=%b exp %b", e, obs, exp_v);
      end
    end
    settle();
  endtask

  // Debounced fall lands on E20 = N+15, where the second repeat would fire.
  task automatic test_collision();
    logic rep;
    i_btn = 1'b1;
    for (int e = 0; e <= 35; e++) begin
      tick();
      if (e == 14) i_btn = 1'b0;
      rep = REP_EN && (e == 15);
      exp_v = {(e >= 5 && e < 20), (e == 5), (e == 20), rep, (e == 5) || rep};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL collision E%0d {db,press,rel,rep,step}=%b exp %b", e, obs, exp_v);
      end
    end
    settle();
  endtask

  // Reset for one cycle at E18 while held; fresh press 6 edges later.
  task automatic test_reset_mid_hold();
    i_btn = 1'b1;
    repeat (18) tick();
    i_rst = 1'b1;
    tick();
    exp_v = 5'b00000;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_hold_rst {db,press,rel,rep,step}=%b exp %b", obs, exp_v);
    end
    i_rst = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      tick();
      exp_v = {(r >= 6), (r == 6), 1'b0, 1'b0, (r == 6)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_hold R+%0d {db,press,rel,rep,step}=%b exp %b", r, obs, exp_v);
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_hold_repeat();
    test_collision();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
